slot_board: RTL and testbench
=============================

# slot_board

Parametrised game-board controller that generalises the single-slot latch cell into a bank of `N_SLOTS` two-player slots.
- Accepts moves through a valid/ready handshake and rejects illegal ones.
- Alternates turns, counts moves, and declares game over when the board is full or (optionally) a line is won.
- Sits between the input-decoding front end and the LED/display driver; its `Q` bus replaces the per-slot `Q` outputs of the previous generation.

## Interface
Parameters:
- `N_SLOTS`, 9: number of slots, range 2–15; slot indices 0..N_SLOTS-1, row-major.
- `IDX_W`, 4: width of `MOVE_IDX`; must satisfy 2^IDX_W ≥ N_SLOTS.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `CLEAR`  in  1  synchronous new-game request, active-high.
- `MOVE_VALID`  in  1  move request.
- `MOVE_IDX`  in  IDX_W  target slot of the move.
- `MOVE_READY`  out  1  block can accept a move this cycle.
- `MOVE_ACK`  out  1  one-cycle pulse: move committed.
- `MOVE_ERR`  out  1  one-cycle pulse: move rejected.
- `Q`  out  2*N_SLOTS  slot owners; slot i occupies `[2i+1:2i]`. Encoding: 00 empty, 01 X, 10 O. 11 never occurs.
- `TURN`  out  1  player to move next: 0 = X, 1 = O.
- `MOVE_CNT`  out  IDX_W+1  committed moves since the last reset or clear.
- `GAME_OVER`  out  1  high while in state OVER.
- `WINNER`  out  2  winning player, same encoding as a slot; 00 means none or draw.

## Operation
- FSM has three states: PLAY, CHECK, OVER. Reset state is PLAY.
- PLAY
  - `MOVE_READY`=1.
  - A handshake occurs when `MOVE_VALID`=1 and `MOVE_READY`=1.
  - Illegal move (`MOVE_IDX` ≥ N_SLOTS, or target slot non-empty):
    - `MOVE_ERR` pulses; no other state changes; FSM stays in PLAY.
  - Legal move:
    - Target slot ← TURN+1 (01 or 10); `TURN` toggles; `MOVE_CNT` increments.
    - `MOVE_ACK` pulses; FSM goes to CHECK.
- CHECK
  - `MOVE_READY`=0. Evaluates the board on registered `Q`.
  - If a win is detected (see Configuration) or `MOVE_CNT`==N_SLOTS: go to OVER; `WINNER` is loaded (00 on a full board with no win).
  - Otherwise return to PLAY.
- OVER
  - `MOVE_READY`=0 and `GAME_OVER`=1.
  - `MOVE_VALID` is ignored: no ACK, no ERR.
  - Only `CLEAR` or `RESET` exits.
- `CLEAR` is valid in every state and has priority over everything else.
  - Next edge: all slots 00, `TURN`=0, `MOVE_CNT`=0, `WINNER`=00, FSM in PLAY, no ACK/ERR pulse.
  - A move presented in the same cycle as `CLEAR` is dropped.
- `MOVE_ACK` and `MOVE_ERR` are never high together.
- `MOVE_CNT` never exceeds N_SLOTS.

## Timing
- Reset values, applied asynchronously on `RESET`=0:
  - `Q`=0, `TURN`=0, `MOVE_CNT`=0, `WINNER`=00.
  - `GAME_OVER`=0, `MOVE_ACK`=0, `MOVE_ERR`=0.
  - FSM in PLAY, so `MOVE_READY`=1 once reset is released.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Handshake sampled at edge k:
  - `Q`, `TURN`, `MOVE_CNT` and the ACK/ERR pulse are visible after edge k.
  - Legal move: `MOVE_READY`=0 during cycle k+1 (CHECK).
  - `GAME_OVER`/`WINNER` are valid after edge k+1, or `MOVE_READY` is 1 again after edge k+1.
- Maximum accepted rate is one legal move every 2 cycles. Illegal moves can repeat every cycle.
- `RESET` asserted mid-CHECK or mid-OVER returns the block to the reset state immediately. A pending evaluation is discarded.

## Configuration
- Macro `SLOT_BOARD_WIN_EN`.
- Defined:
  - CHECK evaluates the 8 lines of a 3×3 board: rows {0,1,2}, {3,4,5}, {6,7,8}; columns {0,3,6}, {1,4,7}, {2,5,8}; diagonals {0,4,8}, {2,4,6}.
  - A line whose three slots are equal and non-zero ends the game, and `WINNER` = that code.
  - A win on the 9th move reports the winner, not a draw.
  - Requires N_SLOTS==9; any other value is an elaboration error.
- Not defined:
  - No line logic. OVER is entered only on a full board, and `WINNER` is always 00.
  - Any N_SLOTS in range is allowed.

## Test plan
- Reset check: reset, then release → `Q`=0, `TURN`=0, `MOVE_CNT`=0, `MOVE_READY`=1, `GAME_OVER`=0.
- Legal then duplicate move: move idx 4 → `MOVE_ACK`, `Q[9:8]`=01, `TURN`=1, `MOVE_CNT`=1. Repeat idx 4 → `MOVE_ERR`, nothing else changes. Move idx 15 → `MOVE_ERR`.
- Full board, N_SLOTS=9, macro off: fill idx 0..8 in order → after the 9th CHECK, `GAME_OVER`=1, `WINNER`=00. A further move gives neither ACK nor ERR.
- Row win, macro on: X plays 0, 1, 2 while O plays 3, 4 → after the move at idx 2 plus one cycle, `GAME_OVER`=1, `WINNER`=01, `MOVE_CNT`=5.
- Clear priority: `CLEAR` and a legal `MOVE_VALID` in the same cycle, from mid-game and from OVER → board empty, `TURN`=0, FSM in PLAY, no ACK.
- Async reset: drop `RESET` during CHECK, between edges → outputs take reset values before the next edge.

Source files
------------

// File: rtl/slot_board.sv
`default_nettype none
// ============================================================================
// Module   : slot_board
// Purpose  : Two-player game-board controller over N_SLOTS slots. Accepts
//            moves through a valid/ready handshake and rejects illegal ones.
//            It alternates turns, counts moves and declares game over on a
//            full board or, when SLOT_BOARD_WIN_EN is defined, on a
//            3x3 line win.
// Options  : `define SLOT_BOARD_WIN_EN enables 3x3 line-win detection
//            (N_SLOTS must be 9).
// Revision : 1.0 - initial release
// ============================================================================
module slot_board #(
  parameter int N_SLOTS = 9,
  parameter int IDX_W   = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CLEAR,
  input  logic                 MOVE_VALID,
  input  logic [IDX_W-1:0]     MOVE_IDX,
  output logic                 MOVE_READY,
  output logic                 MOVE_ACK,
  output logic                 MOVE_ERR,
  output logic [2*N_SLOTS-1:0] Q,
  output logic                 TURN,
  output logic [IDX_W:0]       MOVE_CNT,
  output logic                 GAME_OVER,
  output logic [1:0]           WINNER
);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  localparam int           c_IDX_SPAN = 2 ** IDX_W;
  localparam logic [IDX_W:0] c_FULL_CNT = (IDX_W+1)'(N_SLOTS);

  if (c_IDX_SPAN < N_SLOTS) begin : g_idx_w_check
    $error("slot_board: IDX_W too narrow for N_SLOTS");
  end

  state_t                 r_state, w_state_nxt;
  logic [2*N_SLOTS-1:0]   r_q, w_q_nxt;
  logic                   r_turn, w_turn_nxt;
  logic [IDX_W:0]         r_cnt, w_cnt_nxt;
  logic [1:0]             r_winner, w_winner_nxt;
  logic                   r_ack, w_ack_nxt;
  logic                   r_err, w_err_nxt;

  // Busy map covers the whole index space; out-of-range indices read as busy,
  // which folds the range check and the occupancy check into one lookup.
  logic [c_IDX_SPAN-1:0]  w_busy;
  logic [2*N_SLOTS-1:0]   w_mark;
  logic [1:0]             w_win;

  for (genvar gi = 0; gi < c_IDX_SPAN; gi++) begin : g_busy
    if (gi < N_SLOTS) begin : g_slot
      assign w_busy[gi] = |r_q[2*gi +: 2];
    end else begin : g_pad
      assign w_busy[gi] = 1'b1;
    end
  end

  // Code of the player to move ({TURN, ~TURN}: X=01, O=10) placed at MOVE_IDX.
  for (genvar gs = 0; gs < N_SLOTS; gs++) begin : g_mark
    assign w_mark[2*gs +: 2] = (MOVE_IDX == IDX_W'(gs)) ? {r_turn, ~r_turn} : 2'b00;
  end

`ifdef SLOT_BOARD_WIN_EN
  if (N_SLOTS != 9) begin : g_win_size_check
    $error("slot_board: SLOT_BOARD_WIN_EN requires N_SLOTS == 9");
  end

  localparam int c_LINES [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  // First line whose three slots hold the same non-empty code.
  always_comb begin
    w_win = 2'b00;
    for (int l = 0; l < 8; l++) begin
      if (w_win == 2'b00 &&
          r_q[2*c_LINES[l][0] +: 2] != 2'b00 &&
          r_q[2*c_LINES[l][0] +: 2] == r_q[2*c_LINES[l][1] +: 2] &&
          r_q[2*c_LINES[l][1] +: 2] == r_q[2*c_LINES[l][2] +: 2]) begin
        w_win = r_q[2*c_LINES[l][0] +: 2];
      end
    end
  end
`else
  assign w_win = 2'b00;
`endif

  // Next-state and next-register decode; CLEAR overrides every state.
  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_turn_nxt   = r_turn;
    w_cnt_nxt    = r_cnt;
    w_winner_nxt = r_winner;
    w_ack_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    if (CLEAR) begin
      w_state_nxt  = ST_PLAY;
      w_q_nxt      = '0;
      w_turn_nxt   = 1'b0;
      w_cnt_nxt    = '0;
      w_winner_nxt = 2'b00;
    end else begin
      case (r_state)
        ST_PLAY: begin
          if (MOVE_VALID) begin
            if (w_busy[MOVE_IDX]) begin
              w_err_nxt = 1'b1;
            end else begin
              w_q_nxt     = r_q | w_mark;
              w_turn_nxt  = ~r_turn;
              w_cnt_nxt   = r_cnt + 1'b1;
              w_ack_nxt   = 1'b1;
              w_state_nxt = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (w_win != 2'b00 || r_cnt == c_FULL_CNT) begin
            w_state_nxt  = ST_OVER;
            w_winner_nxt = w_win;
          end else begin
            w_state_nxt = ST_PLAY;
          end
        end
        ST_OVER: begin
          w_state_nxt = ST_OVER;
        end
        default: begin
          w_state_nxt = ST_PLAY;
        end
      endcase
    end
  end

  // State and board registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= ST_PLAY;
      r_q      <= '0;
      r_turn   <= 1'b0;
      r_cnt    <= '0;
      r_winner <= 2'b00;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_turn   <= w_turn_nxt;
      r_cnt    <= w_cnt_nxt;
      r_winner <= w_winner_nxt;
      r_ack    <= w_ack_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign MOVE_READY = (r_state == ST_PLAY);
  assign GAME_OVER  = (r_state == ST_OVER);
  assign MOVE_ACK   = r_ack;
  assign MOVE_ERR   = r_err;
  assign Q          = r_q;
  assign TURN       = r_turn;
  assign MOVE_CNT   = r_cnt;
  assign WINNER     = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_slot_board.sv
`default_nettype none
// ============================================================================
// Module   : tb_slot_board
// Purpose  : Self-checking bench for slot_board: directed scenarios followed
//            by randomized moves, compared against a behavioural game model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slot_board;

  localparam int N = 9;
  localparam int W = 4;

  logic           CLK = 1'b0;
  logic           RESET = 1'b0;
  logic           CLEAR = 1'b0;
  logic           MOVE_VALID = 1'b0;
  logic [W-1:0]   MOVE_IDX = '0;
  logic           MOVE_READY, MOVE_ACK, MOVE_ERR, TURN, GAME_OVER;
  logic [2*N-1:0] Q;
  logic [W:0]     MOVE_CNT;
  logic [1:0]     WINNER;

  int errors = 0;
  int checks = 0;

  // Behavioural game model
  int board [N];
  int m_turn, m_cnt, m_winner;
  bit m_pend, m_over, m_ack, m_err;
  int lines [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  slot_board #(.N_SLOTS(N), .IDX_W(W)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .CLEAR      (CLEAR),
    .MOVE_VALID (MOVE_VALID),
    .MOVE_IDX   (MOVE_IDX),
    .MOVE_READY (MOVE_READY),
    .MOVE_ACK   (MOVE_ACK),
    .MOVE_ERR   (MOVE_ERR),
    .Q          (Q),
    .TURN       (TURN),
    .MOVE_CNT   (MOVE_CNT),
    .GAME_OVER  (GAME_OVER),
    .WINNER     (WINNER)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_win();
`ifdef SLOT_BOARD_WIN_EN
    for (int l = 0; l < 8; l++) begin
      if (board[lines[l][0]] != 0 && board[lines[l][0]] == board[lines[l][1]] &&
          board[lines[l][1]] == board[lines[l][2]])
        return board[lines[l][0]];
    end
`endif
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) board[i] = 0;
    m_turn = 0; m_cnt = 0; m_winner = 0;
    m_pend = 0; m_over = 0; m_ack = 0; m_err = 0;
  endtask

  // One clock edge of the game rules.
  task automatic model_edge(input bit clr, input bit vld, input int idx);
    int w;
    m_ack = 0;
    m_err = 0;
    if (clr) begin
      model_reset();
    end else if (m_pend) begin
      m_pend = 0;
      w = model_win();
      if (w != 0 || m_cnt == N) begin
        m_over = 1;
        m_winner = w;
      end
    end else if (!m_over && vld) begin
      if (idx >= N || board[idx] != 0) begin
        m_err = 1;
      end else begin
        board[idx] = m_turn + 1;
        m_turn = 1 - m_turn;
        m_cnt++;
        m_ack = 1;
        m_pend = 1;
      end
    end
  endtask

  task automatic check_all(input string ctx);
    logic [2*N-1:0] exp_q;
    int v;
    for (int i = 0; i < N; i++) begin
      v = board[i];
      exp_q[2*i +: 2] = v[1:0];
    end
    check_eq({ctx, ".q"},      32'(Q),          32'(exp_q));
    check_eq({ctx, ".turn"},   32'(TURN),       32'(m_turn));
    check_eq({ctx, ".cnt"},    32'(MOVE_CNT),   32'(m_cnt));
    check_eq({ctx, ".ack"},    32'(MOVE_ACK),   32'(m_ack));
    check_eq({ctx, ".err"},    32'(MOVE_ERR),   32'(m_err));
    check_eq({ctx, ".ready"},  32'(MOVE_READY), 32'(!m_pend && !m_over));
    check_eq({ctx, ".over"},   32'(GAME_OVER),  32'(m_over));
    check_eq({ctx, ".winner"}, 32'(WINNER),     32'(m_winner));
  endtask

  // Present inputs, take one edge, update the model, compare 1ns later.
  task automatic step(input string ctx, input bit clr, input bit vld, input int idx);
    CLEAR      = clr;
    MOVE_VALID = vld;
    MOVE_IDX   = idx[W-1:0];
    @(posedge CLK);
    model_edge(clr, vld, idx);
    #1;
    check_all(ctx);
  endtask

  task automatic play(input string ctx, input int idx);
    step(ctx, 1'b0, 1'b1, idx);
    step({ctx, "_chk"}, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int r, idx;
    bit clr, vld;
    model_reset();
    #3;
    check_all("rst_low");
    #14 RESET = 1'b1;
    #1;
    check_eq("rst_ready", 32'(MOVE_READY), 32'd1);

    // Legal move, duplicate, out of range
    step("mv4", 1'b0, 1'b1, 4);
    check_eq("mv4_slot", 32'(Q[9:8]), 32'd1);
    check_eq("mv4_ack", 32'(MOVE_ACK), 32'd1);
    step("mv4_chk", 1'b0, 1'b0, 0);
    step("dup4", 1'b0, 1'b1, 4);
    check_eq("dup4_err", 32'(MOVE_ERR), 32'd1);
    step("idx15", 1'b0, 1'b1, 15);
    check_eq("idx15_err", 32'(MOVE_ERR), 32'd1);
    step("idle", 1'b0, 1'b0, 0);

    // Clear mid-game with a legal move in the same cycle
    step("clr_mid", 1'b1, 1'b1, 0);
    check_eq("clr_mid_q", 32'(Q), 32'd0);

    // Fill the board in index order
    for (int i = 0; i < N; i++) begin
      if (!m_over) play("fill", i);
    end
`ifndef SLOT_BOARD_WIN_EN
    check_eq("full_over", 32'(GAME_OVER), 32'd1);
    check_eq("full_winner", 32'(WINNER), 32'd0);
`endif
    step("over_move", 1'b0, 1'b1, 0);
    step("clr_over", 1'b1, 1'b1, 3);
    check_eq("clr_over_ready", 32'(MOVE_READY), 32'd1);

`ifdef SLOT_BOARD_WIN_EN
    play("row", 0); play("row", 3); play("row", 1); play("row", 4); play("row", 2);
    check_eq("row_winner", 32'(WINNER), 32'd1);
    check_eq("row_cnt", 32'(MOVE_CNT), 32'd5);
    step("row_clr", 1'b1, 1'b0, 0);
`endif

    // Asynchronous reset while the move is being evaluated
    step("pre_async", 1'b0, 1'b1, 5);
    #2 RESET = 1'b0;
    model_reset();
    #1;
    check_all("async");
    #2 RESET = 1'b1;

    // Randomized play
    for (int n = 0; n < 3000; n++) begin
      r   = $urandom_range(0, 99);
      clr = (r < 3);
      vld = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) idx = $urandom_range(9, 15);
      else idx = $urandom_range(0, 8);
      step("rnd", clr, vld, idx);
    end

    CLEAR = 1'b0;
    MOVE_VALID = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
